// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, imem req/ack fetch, redirect/flush, stall hold, timeout error.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect targets raise fetch_error.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump_en,
    input  logic [25:0] jump_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] p_count,
    output logic        instr_valid,
    output logic        fetch_error
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam int             CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  WAIT_LAST = CW'(MAX_WAIT - 1);

    logic [2:0]    state;
    logic [31:0]   pc;
    logic [31:0]   drain_addr;
    logic [CW-1:0] wait_cnt;

    logic          redirect;
    logic          hold_now;
    logic          timeout;
    logic [31:0]   jump_tgt;
    logic [31:0]   branch_tgt;
    logic [31:0]   raw_tgt;
    logic [31:0]   tgt;
    logic          misalign;

    assign redirect   = instr_valid && (jump_en || branch_taken);
    // A stalled decode still holding a valid word must not have it overwritten.
    assign hold_now   = (state == S_FETCH) && stall && instr_valid && !redirect;

    assign imem_req   = !reset && (((state == S_FETCH) && !hold_now) ||
                                   (state == S_WAIT) || (state == S_DRAIN));
    assign imem_addr  = (state == S_DRAIN) ? drain_addr : pc;
    assign timeout    = imem_req && !imem_ack && (wait_cnt == WAIT_LAST);

    assign jump_tgt   = {p_count[31:28], jump_address, 2'b00};
    assign branch_tgt = p_count + (branch_offset << 2);
    assign raw_tgt    = jump_en ? jump_tgt : branch_tgt;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign   = (raw_tgt[1:0] != 2'b00);
    assign tgt        = raw_tgt;
`else
    assign misalign   = 1'b0;
    assign tgt        = raw_tgt & ~32'h3;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            drain_addr  <= RESET_PC;
            wait_cnt    <= '0;
            instruction <= 32'h0;
            p_count     <= 32'h0;
            instr_valid <= 1'b0;
            fetch_error <= 1'b0;
        end else if (timeout) begin
            state       <= S_ERROR;
            fetch_error <= 1'b1;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            // Flush wins over any capture this cycle; an unacked request must be drained.
            instr_valid <= 1'b0;
            if (misalign) begin
                state       <= S_ERROR;
                fetch_error <= 1'b1;
            end else begin
                pc <= tgt;
                if (imem_req && !imem_ack) begin
                    state      <= S_DRAIN;
                    drain_addr <= pc;
                    wait_cnt   <= wait_cnt + CW'(1);
                end else begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                end
            end
        end else begin
            case (state)
                S_FETCH, S_WAIT: begin
                    if (hold_now) begin
                        state <= S_HOLD;
                    end else if (imem_ack) begin
                        instruction <= imem_rdata;
                        p_count     <= pc + 32'd4;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                        wait_cnt    <= '0;
                        state       <= stall ? S_HOLD : S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                        state    <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!stall) state <= S_FETCH;
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        wait_cnt <= '0;
                        state    <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_ERROR: begin
                    instr_valid <= 1'b0;
                end
                default: state <= S_ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed table-driven bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump_en;
    logic [25:0] jump_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] p_count;
    logic        instr_valid;
    logic        fetch_error;

    int checks = 0;
    int passed = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump_en      (jump_en),
        .jump_address (jump_address),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .p_count      (p_count),
        .instr_valid  (instr_valid),
        .fetch_error  (fetch_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        bt;
        logic [31:0] boff;
        logic        je;
        logic [25:0] ja;
        logic        ack;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] ins;
        logic [31:0] pcn;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic st, logic bt, logic [31:0] boff, logic je, logic [25:0] ja,
                                logic ack, logic [31:0] rd, logic req, logic [31:0] addr,
                                logic v, logic [31:0] ins, logic [31:0] pcn);
        vec_t r;
        r.st = st; r.bt = bt; r.boff = boff; r.je = je; r.ja = ja; r.ack = ack; r.rd = rd;
        r.req = req; r.addr = addr; r.v = v; r.ins = ins; r.pcn = pcn;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic st, input logic bt, input logic [31:0] boff,
                         input logic je, input logic [25:0] ja, input logic ack, input logic [31:0] rd);
        stall = st; branch_taken = bt; branch_offset = boff;
        jump_en = je; jump_address = ja; imem_ack = ack; imem_rdata = rd;
    endtask

    // Holds reset across two rising edges, checks reset outputs, then releases at negedge+1.
    task automatic do_reset(input logic ack_during);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, ack_during, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_err",   {31'b0, fetch_error}, 32'd0);
        chk("rst_instr", instruction,          32'd0);
        chk("rst_pcnt",  p_count,              32'd0);
        chk("rst_addr",  imem_addr,            32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int bad;
        tbl[0]  = mk(0,0,32'h0,0,26'h0,1,32'h1000_0000, 1,32'h0000_0000,0,32'h0,32'h0);
        tbl[1]  = mk(0,0,32'h0,0,26'h0,1,32'h1000_0004, 1,32'h0000_0004,1,32'h1000_0000,32'h4);
        tbl[2]  = mk(0,0,32'h0,0,26'h0,1,32'h0123_4567, 1,32'h0000_0008,1,32'h1000_0004,32'h8);
        tbl[3]  = mk(1,0,32'h0,0,26'h0,0,32'h0,         0,32'h0000_000C,1,32'h0123_4567,32'hC);
        tbl[4]  = mk(1,0,32'h0,0,26'h0,1,32'hEEEE_EEEE, 0,32'h0000_000C,1,32'h0123_4567,32'hC);
        tbl[5]  = mk(1,0,32'h0,0,26'h0,0,32'h0,         0,32'h0000_000C,1,32'h0123_4567,32'hC);
        tbl[6]  = mk(0,0,32'h0,0,26'h0,0,32'h0,         0,32'h0000_000C,1,32'h0123_4567,32'hC);
        tbl[7]  = mk(0,0,32'h0,0,26'h0,1,32'h2222_2222, 1,32'h0000_000C,1,32'h0123_4567,32'hC);
        tbl[8]  = mk(0,1,32'hFFFF_FFFE,0,26'h0,1,32'h3333_3333, 1,32'h0000_0010,1,32'h2222_2222,32'h10);
        tbl[9]  = mk(0,0,32'h0,0,26'h0,1,32'hAAAA_0008, 1,32'h0000_0008,0,32'h0,32'h0);
        tbl[10] = mk(0,1,32'h0FFF_FFFD,0,26'h0,1,32'hDEAD_BEEF, 1,32'h0000_000C,1,32'hAAAA_0008,32'hC);
        tbl[11] = mk(0,0,32'h0,0,26'h0,1,32'h0800_0100, 1,32'h4000_0000,0,32'h0,32'h0);
        tbl[12] = mk(0,1,32'h4,1,26'h0000100,1,32'h5555_5555, 1,32'h4000_0004,1,32'h0800_0100,32'h4000_0004);
        tbl[13] = mk(0,0,32'h0,0,26'h0,1,32'h6666_6666, 1,32'h4000_0400,0,32'h0,32'h0);
        tbl[14] = mk(0,1,32'h2FFF_FEFE,0,26'h0,1,32'h9999_9999, 1,32'h4000_0404,1,32'h6666_6666,32'h4000_0404);
        tbl[15] = mk(0,0,32'h0,0,26'h0,1,32'h7777_7777, 1,32'hFFFF_FFFC,0,32'h0,32'h0);
        tbl[16] = mk(0,0,32'h0,0,26'h0,0,32'h0,         1,32'h0000_0000,1,32'h7777_7777,32'h0);

        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].st, tbl[i].bt, tbl[i].boff, tbl[i].je, tbl[i].ja, tbl[i].ack, tbl[i].rd);
            #1;
            chk($sformatf("row%0d_req", i),   {31'b0, imem_req},    {31'b0, tbl[i].req});
            chk($sformatf("row%0d_addr", i),  imem_addr,            tbl[i].addr);
            chk($sformatf("row%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].v});
            chk($sformatf("row%0d_err", i),   {31'b0, fetch_error}, 32'd0);
            if (tbl[i].v) begin
                chk($sformatf("row%0d_instr", i), instruction, tbl[i].ins);
                chk($sformatf("row%0d_pcnt", i),  p_count,     tbl[i].pcn);
            end
            @(negedge clk);
        end

        // Redirect while the request at 0x20 is outstanding; its late data must never appear.
        do_reset(1'b0);
        for (int j = 0; j < 8; j++) begin
            drive(0, 0, 0, 0, 0, 1, 32'h100 + 32'(j));
            #1;
            @(negedge clk);
        end
        drive(0, 1, 32'h10, 0, 0, 0, 32'h0);
        #1;
        chk("dr_addr20", imem_addr, 32'h20);
        chk("dr_pcnt20", p_count,   32'h20);
        chk("dr_valid",  {31'b0, instr_valid}, 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        chk("dr_req_held", {31'b0, imem_req},    32'd1);
        chk("dr_flushed",  {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
        #1;
        chk("dr_req_late", {31'b0, imem_req},    32'd1);
        chk("dr_nodata",   {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 32'h1212_1212);
        #1;
        chk("dr_newaddr", imem_addr,            32'h60);
        chk("dr_v0",      {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        chk("dr_v1",    {31'b0, instr_valid}, 32'd1);
        chk("dr_instr", instruction,          32'h1212_1212);
        chk("dr_pcnt",  p_count,              32'h64);
        @(negedge clk);

        // Timeout: ack is also high during reset, and must be ignored.
        do_reset(1'b1);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            drive(0, 0, 0, 0, 0, 0, 32'h0);
            #1;
            if (imem_req !== 1'b1 || fetch_error !== 1'b0 || imem_addr !== 32'h0) bad++;
            @(negedge clk);
        end
        chk("to_wait_cycles", 32'(bad), 32'd0);
        #1;
        chk("to_err",   {31'b0, fetch_error}, 32'd1);
        chk("to_req",   {31'b0, imem_req},    32'd0);
        chk("to_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 32'h0);
        @(negedge clk);
        #1;
        chk("to_sticky", {31'b0, fetch_error}, 32'd1);
        chk("to_noreq",  {31'b0, imem_req},    32'd0);
        @(negedge clk);
        do_reset(1'b0);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        chk("rs_req",  {31'b0, imem_req},    32'd1);
        chk("rs_addr", imem_addr,            32'h0);
        chk("rs_err",  {31'b0, fetch_error}, 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
